// File: rtl/zeroheti_pkg.sv
// Register map offsets, CTRL layout and byte-lane helper shared by the zeroHETI machine timer.
package zeroheti_pkg;

  localparam logic [4:0] MtimerLoOff     = 5'h00;
  localparam logic [4:0] MtimerHiOff     = 5'h04;
  localparam logic [4:0] MtimerCmpLoOff  = 5'h08;
  localparam logic [4:0] MtimerCmpHiOff  = 5'h0C;
  localparam logic [4:0] MtimerCtrlOff   = 5'h10;
  localparam logic [4:0] MtimerStatusOff = 5'h14;

  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  prescale;
    logic [6:0]  rsvd_lo;
    logic        en;
  } mtimer_ctrl_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  // Misaligned, beyond STATUS, or a write to the read-only STATUS word.
  function automatic logic mtimer_addr_err(input logic [4:0] addr, input logic write);
    return (addr[1:0] != 2'b00) || (addr > MtimerStatusOff) ||
           (write && (addr == MtimerStatusOff));
  endfunction

endpackage

// File: rtl/zeroheti_mtimer_cnt.sv
// 64-bit mtime counter with byte-lane write port, optional prescaler and registered compare IRQ.
// Prescaler present only when ZEROHETI_MTIMER_PRESCALER_EN is defined.
module zeroheti_mtimer_cnt
  import zeroheti_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
`ifdef ZEROHETI_MTIMER_PRESCALER_EN
  input  logic [7:0]  prescale,
  input  logic        div_clr,
`endif
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic [63:0] mtimecmp,
  output logic [63:0] mtime,
  output logic        irq
);

  logic [63:0] mtime_q;
  logic        irq_q;
  logic        tick;

`ifdef ZEROHETI_MTIMER_PRESCALER_EN
  logic [7:0] div_q;

  // A tick fires on the cycle the divider reaches PRESCALE, so the period is PRESCALE+1.
  assign tick = en && (div_q == prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= 8'd0;
    end else if (!en || div_clr || tick) begin
      div_q <= 8'd0;
    end else begin
      div_q <= div_q + 8'd1;
    end
  end
`else
  assign tick = en;
`endif

  // Software writes take priority; the tick coinciding with a write is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q <= 64'd0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) mtime_q[31:0]  <= strb_merge(mtime_q[31:0], wdata, wstrb);
      if (wr_hi) mtime_q[63:32] <= strb_merge(mtime_q[63:32], wdata, wstrb);
    end else if (tick) begin
      mtime_q <= mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (mtime_q >= mtimecmp);
    end
  end

  assign mtime = mtime_q;
  assign irq   = irq_q;

endmodule

// File: rtl/zeroheti_apb_mtimer.sv
// APB completer for the RISC-V machine timer: decode, CMP/CTRL registers, MTIME_HI shadow, read mux.
// Optional CTRL.PRESCALE field enabled by ZEROHETI_MTIMER_PRESCALER_EN.
module zeroheti_apb_mtimer
  import zeroheti_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter logic [63:0] CmpReset  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [AddrWidth-1:0] paddr_i,
  input  logic [31:0]          pwdata_i,
  input  logic [3:0]           pstrb_i,
  output logic                 pready_o,
  output logic [31:0]          prdata_o,
  output logic                 pslverr_o,
  output logic                 timer_irq_o
);

  logic [4:0]   addr;
  logic         setup;
  logic         access;
  logic         err;
  logic         wr_ok;
  logic         rd_ok;
  logic         unused_addr;
  logic [63:0]  mtime;
  logic [63:0]  mtimecmp_q;
  logic         en_q;
  logic [31:0]  hi_shadow_q;
  logic [31:0]  prdata_q;
  logic         pslverr_q;
  logic [31:0]  rd_val;
  mtimer_ctrl_t ctrl_rd;
  logic         irq;

  assign addr        = paddr_i[4:0];
  assign unused_addr = ^paddr_i[AddrWidth-1:5];
  assign setup       = psel_i & ~penable_i;
  assign access      = psel_i & penable_i;
  assign err         = mtimer_addr_err(addr, pwrite_i);
  assign wr_ok       = access & pwrite_i & ~err;
  assign rd_ok       = setup & ~pwrite_i & ~err;

`ifdef ZEROHETI_MTIMER_PRESCALER_EN
  logic [7:0] prescale_q;
  logic       ctrl_wr;

  assign ctrl_wr = wr_ok & (addr == MtimerCtrlOff);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtimecmp_q <= CmpReset;
      en_q       <= 1'b0;
`ifdef ZEROHETI_MTIMER_PRESCALER_EN
      prescale_q <= 8'd0;
`endif
    end else if (wr_ok) begin
      case (addr)
        MtimerCmpLoOff: mtimecmp_q[31:0]  <= strb_merge(mtimecmp_q[31:0], pwdata_i, pstrb_i);
        MtimerCmpHiOff: mtimecmp_q[63:32] <= strb_merge(mtimecmp_q[63:32], pwdata_i, pstrb_i);
        MtimerCtrlOff: begin
          if (pstrb_i[0]) en_q <= pwdata_i[0];
`ifdef ZEROHETI_MTIMER_PRESCALER_EN
          if (pstrb_i[1]) prescale_q <= pwdata_i[15:8];
`endif
        end
        default: ;
      endcase
    end
  end

  zeroheti_mtimer_cnt u_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .en       (en_q),
`ifdef ZEROHETI_MTIMER_PRESCALER_EN
    .prescale (prescale_q),
    .div_clr  (ctrl_wr),
`endif
    .wr_lo    (wr_ok & (addr == MtimerLoOff)),
    .wr_hi    (wr_ok & (addr == MtimerHiOff)),
    .wdata    (pwdata_i),
    .wstrb    (pstrb_i),
    .mtimecmp (mtimecmp_q),
    .mtime    (mtime),
    .irq      (irq)
  );

  always_comb begin
    ctrl_rd    = '0;
    ctrl_rd.en = en_q;
`ifdef ZEROHETI_MTIMER_PRESCALER_EN
    ctrl_rd.prescale = prescale_q;
`endif
  end

  always_comb begin
    rd_val = 32'd0;
    case (addr)
      MtimerLoOff:     rd_val = mtime[31:0];
      MtimerHiOff:     rd_val = hi_shadow_q;
      MtimerCmpLoOff:  rd_val = mtimecmp_q[31:0];
      MtimerCmpHiOff:  rd_val = mtimecmp_q[63:32];
      MtimerCtrlOff:   rd_val = ctrl_rd;
      MtimerStatusOff: rd_val = {31'd0, irq};
      default:         rd_val = 32'd0;
    endcase
  end

  // Response is captured in setup so the access cycle sees a stable, coherent value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prdata_q    <= 32'd0;
      pslverr_q   <= 1'b0;
      hi_shadow_q <= 32'd0;
    end else if (setup) begin
      prdata_q  <= rd_ok ? rd_val : 32'd0;
      pslverr_q <= err;
      if (rd_ok && (addr == MtimerLoOff)) hi_shadow_q <= mtime[63:32];
    end
  end

  assign pready_o    = access & ~rst_i;
  assign prdata_o    = prdata_q;
  assign pslverr_o   = pslverr_q;
  assign timer_irq_o = irq;

endmodule
